dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_W, 16, width of settle counter and settle_cycles_i.
REQ-002 Parameter DWELL_W, 24, width of dwell counter and dwell_cycles_i.
REQ-003 Parameter IDX_W, 16, width of point index.
REQ-004 sys_clk  in  1  single clock; all logic rising-edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  sweep start request, sampled in IDLE only.
REQ-007 abort_i  in  1  terminate sweep, any state.
REQ-008 start_freq_i / stop_freq_i / step_freq_i  in  32 each  unsigned sweep limits and step magnitude (DDS frequency units).
REQ-009 settle_cycles_i  in  SETTLE_W  post-retune settle time; dwell_cycles_i  in  DWELL_W  measurement window length.
REQ-010 wave_sel_i  in  4  one-hot waveform (0001 sin, 0010 squ, 0100 tri, 1000 saw).
REQ-011 pt_ready_i  in  1  downstream lock-in has captured current point.
REQ-012 freq_o  out  32  frequency word to DDS; wave_select_o  out  4  waveform to DDS.
REQ-013 meas_en_o  out  1  measurement window; pt_valid_o  out  1  point complete; pt_idx_o  out  IDX_W  current point index.
REQ-014 busy_o  out  1  sweep active; done_o  out  1  one-cycle completion pulse.

Function
REQ-015 States: IDLE, LOAD, SETTLE, DWELL, PT_WAIT, STEP, DONE; all outputs registered.
REQ-016 IDLE & start_i -> LOAD; all *_i config latched into shadow registers that cycle; later config changes ignored until next start.
REQ-017 LOAD: freq_o <= start_freq, wave_select_o <= wave_sel, pt_idx_o <= 0, busy_o <= 1; -> SETTLE.
REQ-018 SETTLE: hold settle_cycles clocks, then -> DWELL; settle_cycles=0 goes straight to DWELL.
REQ-019 DWELL: meas_en_o=1 for exactly max(dwell_cycles,1) clocks, then -> PT_WAIT.
REQ-020 PT_WAIT: pt_valid_o=1, freq_o stable; pt_ready_i high -> STEP, pt_valid_o drops next cycle; pt_valid_o never drops without pt_ready_i except on abort/reset.
REQ-021 Direction: up if stop >= start, else down; fixed for the sweep.
REQ-022 STEP: next = freq_o ± step computed in 33 bits; if freq_o == stop, or step == 0 -> DONE; else if next passes or equals stop (incl. 33-bit overflow/underflow) freq_o <= stop; else freq_o <= next; pt_idx_o += 1; -> SETTLE.
REQ-023 pt_idx_o saturates at all-ones; sweep continues.
REQ-024 DONE: done_o=1 one cycle, busy_o <= 0, freq_o and wave_select_o hold last value; -> IDLE.
REQ-025 abort_i in any non-IDLE state: next cycle IDLE, busy_o/meas_en_o/pt_valid_o = 0, no done_o; freq_o holds; abort has priority over start and pt_ready_i.
REQ-026 start_i while busy ignored; start_i and abort_i together in IDLE: abort wins, stay IDLE.
REQ-027 start == stop: single point, then DONE.
REQ-028 wave_select_o changes only in LOAD (DDS resets phase accumulator on waveform change).

Reset
REQ-029 sys_rst synchronous: state IDLE, freq_o=0, wave_select_o=4'b0001, pt_idx_o=0, busy_o/done_o/meas_en_o/pt_valid_o=0; reset mid-sweep abandons sweep without done_o.

Configuration
REQ-030 DDS_SWEEP_REPEAT_EN defined: add input repeat_i (latched at start); at DONE with repeat set, emit done_o and return to LOAD (pt_idx_o restarts at 0, busy_o stays 1) until abort_i.
REQ-031 DDS_SWEEP_REPEAT_EN undefined: no repeat_i port; behaviour per REQ-024.

Structure
REQ-032 Shared package holds state enum, wave one-hot constants (SIN/SQU/TRI/SAW), reset-default waveform.
REQ-033 One sub-module dds_sweep_step: combinational 33-bit next-frequency/clamp/last-point logic.

Verification
REQ-034 start=1000, stop=1300, step=100, settle=4, dwell=8, pt_ready tied high -> freq_o 1000,1100,1200,1300; pt_idx 0..3; 8 meas_en clocks per point; single done_o.
REQ-035 start=1000, stop=1250, step=100 -> freq_o 1000,1100,1200,1250 (clamped); start=500, stop=200, step=200 -> 500,300,200.
REQ-036 start=FFFF_FF00, stop=FFFF_FFFF, step=0x80 -> FFFF_FF00, FFFF_FF80, FFFF_FFFF, no wrap to low values.
REQ-037 pt_ready held low 50 cycles in PT_WAIT -> pt_valid_o stays high, freq_o stable; abort in DWELL -> next cycle IDLE, meas_en_o=0, no done_o.
REQ-038 settle=0, dwell=0, start=stop=42 -> SETTLE skipped, meas_en_o one clock, one point, done_o; sys_rst mid-sweep -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and constants for the DDS frequency sweep controller.
// States, one-hot waveform codes and the reset-default waveform.
package dds_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_DWELL,
    S_PT_WAIT,
    S_STEP,
    S_DONE
  } state_e;

  localparam logic [3:0] WAVE_SIN = 4'b0001;
  localparam logic [3:0] WAVE_SQU = 4'b0010;
  localparam logic [3:0] WAVE_TRI = 4'b0100;
  localparam logic [3:0] WAVE_SAW = 4'b1000;
  localparam logic [3:0] WAVE_RST = WAVE_SIN;

endpackage

// File: rtl/dds_sweep_step.sv
// Next sweep frequency: 33-bit step, clamp to stop, last-point detect.
// Carry/borrow out of bit 31 counts as passing the stop frequency.
module dds_sweep_step (
  input  logic [31:0] freq,
  input  logic [31:0] stop,
  input  logic [31:0] step,
  input  logic        up,
  output logic [31:0] next_freq,
  output logic        last
);

  logic [32:0] sum;
  logic        pass;

  always_comb begin
    if (up) begin
      sum  = {1'b0, freq} + {1'b0, step};
      pass = sum >= {1'b0, stop};
    end else begin
      sum  = {1'b0, freq} - {1'b0, step};
      pass = sum[32] || (sum[31:0] <= stop);
    end
    next_freq = pass ? stop : sum[31:0];
    last      = (freq == stop) || (step == '0);
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller: settle, dwell, handshake, step.
// Optional DDS_SWEEP_REPEAT_EN adds repeat_i for continuous sweeping.
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_W = 16,
  parameter int DWELL_W  = 24,
  parameter int IDX_W    = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [31:0]         start_freq_i,
  input  logic [31:0]         stop_freq_i,
  input  logic [31:0]         step_freq_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  input  logic [DWELL_W-1:0]  dwell_cycles_i,
  input  logic [3:0]          wave_sel_i,
  input  logic                pt_ready_i,
`ifdef DDS_SWEEP_REPEAT_EN
  input  logic                repeat_i,
`endif
  output logic [31:0]         freq_o,
  output logic [3:0]          wave_select_o,
  output logic                meas_en_o,
  output logic                pt_valid_o,
  output logic [IDX_W-1:0]    pt_idx_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNT_W =
    (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;

  state_e state_q, state_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    settle_ld, dwell_ld;
  logic [31:0]         start_q, stop_q, step_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [3:0]          wave_q;
  logic                up_q;
  logic                latch;
  logic                go_settle;
  logic [31:0]         freq_d;
  logic [3:0]          wave_d;
  logic [IDX_W-1:0]    idx_d;
  logic                busy_d;
  logic [31:0]         nxt_freq;
  logic                last_pt;
`ifdef DDS_SWEEP_REPEAT_EN
  logic                repeat_q;
`endif

  dds_sweep_step u_step (
    .freq      (freq_o),
    .stop      (stop_q),
    .step      (step_q),
    .up        (up_q),
    .next_freq (nxt_freq),
    .last      (last_pt)
  );

  assign settle_ld = CNT_W'(settle_q);
  assign dwell_ld  = (dwell_q == '0) ?
                     CNT_W'(1) : CNT_W'(dwell_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    freq_d    = freq_o;
    wave_d    = wave_select_o;
    idx_d     = pt_idx_o;
    latch     = 1'b0;
    go_settle = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_LOAD;
          latch   = 1'b1;
        end
      end
      S_LOAD: begin
        freq_d    = start_q;
        wave_d    = wave_q;
        idx_d     = '0;
        go_settle = 1'b1;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DWELL;
          cnt_d   = dwell_ld;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_PT_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PT_WAIT: begin
        if (pt_ready_i) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (last_pt) begin
          state_d = S_DONE;
        end else begin
          freq_d    = nxt_freq;
          idx_d     = (&pt_idx_o) ? pt_idx_o :
                      pt_idx_o + 1'b1;
          go_settle = 1'b1;
        end
      end
      S_DONE: begin
`ifdef DDS_SWEEP_REPEAT_EN
        state_d = repeat_q ? S_LOAD : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Zero settle time skips straight into the dwell window
    if (go_settle) begin
      if (settle_q == '0) begin
        state_d = S_DWELL;
        cnt_d   = dwell_ld;
      end else begin
        state_d = S_SETTLE;
        cnt_d   = settle_ld;
      end
    end

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      freq_d  = freq_o;
      wave_d  = wave_select_o;
      idx_d   = pt_idx_o;
    end

`ifdef DDS_SWEEP_REPEAT_EN
    busy_d = (state_d != S_IDLE) &&
             !((state_d == S_DONE) && !repeat_q);
`else
    busy_d = (state_d != S_IDLE) &&
             (state_d != S_DONE);
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      freq_o        <= '0;
      wave_select_o <= WAVE_RST;
      pt_idx_o      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      meas_en_o     <= 1'b0;
      pt_valid_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      freq_o        <= freq_d;
      wave_select_o <= wave_d;
      pt_idx_o      <= idx_d;
      busy_o        <= busy_d;
      done_o        <= (state_d == S_DONE);
      meas_en_o     <= (state_d == S_DWELL);
      pt_valid_o    <= (state_d == S_PT_WAIT);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      settle_q <= '0;
      dwell_q  <= '0;
      wave_q   <= WAVE_RST;
      up_q     <= 1'b1;
`ifdef DDS_SWEEP_REPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else if (latch) begin
      start_q  <= start_freq_i;
      stop_q   <= stop_freq_i;
      step_q   <= step_freq_i;
      settle_q <= settle_cycles_i;
      dwell_q  <= dwell_cycles_i;
      wave_q   <= wave_sel_i;
      up_q     <= (stop_freq_i >= start_freq_i);
`ifdef DDS_SWEEP_REPEAT_EN
      repeat_q <= repeat_i;
`endif
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized self-checking bench for dds_sweep_ctrl.
// Expected point lists come from plain 64-bit sweep arithmetic.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] start_freq_i = '0;
  logic [31:0] stop_freq_i = '0;
  logic [31:0] step_freq_i = '0;
  logic [15:0] settle_cycles_i = '0;
  logic [23:0] dwell_cycles_i = '0;
  logic [3:0]  wave_sel_i = 4'b0001;
  logic        pt_ready_i = 1'b0;
`ifdef DDS_SWEEP_REPEAT_EN
  logic        repeat_i = 1'b0;
`endif
  logic [31:0] freq_o;
  logic [3:0]  wave_select_o;
  logic        meas_en_o;
  logic        pt_valid_o;
  logic [15:0] pt_idx_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .sys_clk         (clk),
    .sys_rst         (sys_rst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .start_freq_i    (start_freq_i),
    .stop_freq_i     (stop_freq_i),
    .step_freq_i     (step_freq_i),
    .settle_cycles_i (settle_cycles_i),
    .dwell_cycles_i  (dwell_cycles_i),
    .wave_sel_i      (wave_sel_i),
    .pt_ready_i      (pt_ready_i),
`ifdef DDS_SWEEP_REPEAT_EN
    .repeat_i        (repeat_i),
`endif
    .freq_o          (freq_o),
    .wave_select_o   (wave_select_o),
    .meas_en_o       (meas_en_o),
    .pt_valid_o      (pt_valid_o),
    .pt_idx_o        (pt_idx_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  task automatic check_idle_outputs(input string tag,
                                    input logic [31:0] f,
                                    input logic [3:0] w);
    checks++;
    if (freq_o !== f || wave_select_o !== w ||
        pt_idx_o !== 16'd0 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || meas_en_o !== 1'b0 ||
        pt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: f=%h w=%b idx=%0d b=%b d=%b m=%b v=%b want f=%h w=%b rest 0",
               tag, freq_o, wave_select_o, pt_idx_o, busy_o,
               done_o, meas_en_o, pt_valid_o, f, w);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 32'd0, 4'b0001);
    sys_rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset", 32'd0, 4'b0001);
  endtask

  // mode 0: ready tied high, 1: random ready, 2: stall 50 on point 0
  task automatic run_sweep(input string tag,
                           input logic [31:0] s,
                           input logic [31:0] e,
                           input logic [31:0] st,
                           input int settle,
                           input int dwell,
                           input logic [3:0] wv,
                           input int mode);
    longint f;
    longint n;
    logic [31:0] exp_q[$];
    bit up;
    bit fin = 0;
    int pts = 0, gap = 0, mrun = 0, stall = 0;
    int dw;
    logic pv_prev = 0, rdy_prev = 0, m_prev = 0;
    logic [31:0] cur_f = '0;
    dw = (dwell == 0) ? 1 : dwell;
    up = (e >= s);
    f = longint'(s);
    exp_q.push_back(s);
    while (!(f == longint'(e) || st == 0)) begin
      n = up ? f + longint'(st) : f - longint'(st);
      if (up ? (n >= longint'(e)) : (n <= longint'(e)))
        f = longint'(e);
      else
        f = n;
      exp_q.push_back(32'(f));
    end

    start_freq_i    = s;
    stop_freq_i     = e;
    step_freq_i     = st;
    settle_cycles_i = 16'(settle);
    dwell_cycles_i  = 24'(dwell);
    wave_sel_i      = wv;
    pt_ready_i      = 1'b0;
    start_i         = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 5000 && !fin; c++) begin
      if (pv_prev && rdy_prev) begin
        checks++;
        if (pt_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s pv_drop: pv=%b want 0", tag, pt_valid_o);
        end
        pts++;
      end else if (pv_prev) begin
        checks++;
        if (pt_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL %s pv_hold: pv=%b want 1", tag, pt_valid_o);
        end
      end
      if (busy_o && !meas_en_o && !pt_valid_o) gap++;
      if (meas_en_o) begin
        if (!m_prev) begin
          checks++;
          if (gap != settle + 1) begin
            errors++;
            $display("FAIL %s settle: gap=%0d want %0d",
                     tag, gap, settle + 1);
          end
          gap = 0;
        end
        mrun++;
      end else if (m_prev) begin
        checks++;
        if (mrun != dw) begin
          errors++;
          $display("FAIL %s dwell: meas=%0d want %0d", tag, mrun, dw);
        end
        mrun = 0;
      end
      if (pt_valid_o) begin
        gap = 0;
        if (!pv_prev) begin
          checks++;
          if (pts >= exp_q.size()) begin
            errors++;
            $display("FAIL %s extra_pt: pt=%0d f=%h want %0d pts",
                     tag, pts, freq_o, exp_q.size());
          end else if (freq_o !== exp_q[pts] ||
                       pt_idx_o !== 16'(pts) ||
                       wave_select_o !== wv ||
                       busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s point: f=%h idx=%0d w=%b b=%b want f=%h idx=%0d w=%b b=1",
                     tag, freq_o, pt_idx_o, wave_select_o, busy_o,
                     exp_q[pts], pts, wv);
          end
          cur_f = freq_o;
        end else begin
          checks++;
          if (freq_o !== cur_f) begin
            errors++;
            $display("FAIL %s freq_stable: f=%h want %h",
                     tag, freq_o, cur_f);
          end
        end
      end
      if (done_o) begin
        fin = 1;
        checks++;
        if (busy_o !== 1'b0 || freq_o !== exp_q[exp_q.size()-1] ||
            pts != exp_q.size() || wave_select_o !== wv) begin
          errors++;
          $display("FAIL %s done: b=%b f=%h pts=%0d w=%b want b=0 f=%h pts=%0d w=%b",
                   tag, busy_o, freq_o, pts, wave_select_o,
                   exp_q[exp_q.size()-1], exp_q.size(), wv);
        end
      end
      pv_prev = pt_valid_o;
      m_prev  = meas_en_o;
      case (mode)
        0: pt_ready_i = 1'b1;
        1: pt_ready_i = ($urandom_range(0, 2) != 0);
        default: begin
          if (pt_valid_o && pts == 0 && stall < 50) begin
            pt_ready_i = 1'b0;
            stall++;
          end else begin
            pt_ready_i = 1'b1;
          end
        end
      endcase
      rdy_prev = pt_ready_i;
      // configuration noise must be ignored while sweeping
      start_i         = fin ? 1'b0 : 1'($urandom);
      start_freq_i    = $urandom;
      stop_freq_i     = $urandom;
      step_freq_i     = $urandom;
      settle_cycles_i = 16'($urandom);
      dwell_cycles_i  = 24'($urandom);
      wave_sel_i      = 4'($urandom);
      @(negedge clk);
    end
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: no done_o after 5000 cycles", tag);
    end
    start_i = 1'b0;
    pt_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: d=%b b=%b want 0 0",
                 tag, done_o, busy_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    run_sweep("basic", 32'd1000, 32'd1300, 32'd100, 4, 8, 4'b0001, 0);
    run_sweep("clamp_up", 32'd1000, 32'd1250, 32'd100, 2, 3, 4'b0010, 1);
    run_sweep("down", 32'd500, 32'd200, 32'd200, 1, 2, 4'b0100, 1);
    run_sweep("top_edge", 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80,
              1, 1, 4'b1000, 0);
    run_sweep("bot_edge", 32'h0000_0100, 32'h0000_0000, 32'h90,
              0, 1, 4'b0001, 0);
    run_sweep("single", 32'd42, 32'd42, 32'd7, 0, 0, 4'b0010, 0);
    run_sweep("step0", 32'd10, 32'd90, 32'd0, 1, 1, 4'b0100, 0);
  endtask

  task automatic test_stall();
    run_sweep("stall", 32'd300, 32'd100, 32'd100, 2, 2, 4'b1000, 2);
  endtask

  task automatic test_random();
    logic [31:0] s, st;
    longint e;
    logic [3:0] w;
    for (int k = 0; k < 20; k++) begin
      s = ($urandom_range(0, 3) == 0) ?
          (32'hFFFF_FFFF - 32'($urandom_range(0, 4000))) : $urandom;
      case ($urandom_range(0, 3))
        0: st = 32'd0;
        1: st = $urandom;
        default: st = 32'($urandom_range(1, 3000));
      endcase
      e = longint'(s);
      if ($urandom_range(0, 1) == 1)
        e = e + longint'($urandom_range(0, 6)) * longint'(st % 32'd5000)
              + longint'($urandom_range(0, 99));
      else
        e = e - longint'($urandom_range(0, 6)) * longint'(st % 32'd5000)
              - longint'($urandom_range(0, 99));
      if (e < 0) e = 0;
      if (e > 64'hFFFF_FFFF) e = 64'hFFFF_FFFF;
      w = 4'b0001 << $urandom_range(0, 3);
      run_sweep("random", s, 32'(e), st, $urandom_range(0, 3),
                $urandom_range(0, 4), w, $urandom_range(0, 1));
    end
  endtask

  task automatic test_abort();
    logic [31:0] f;
    bit hit = 0;
    start_freq_i    = 32'd7000;
    stop_freq_i     = 32'd9000;
    step_freq_i     = 32'd500;
    settle_cycles_i = 16'd2;
    dwell_cycles_i  = 24'd10;
    wave_sel_i      = 4'b0100;
    pt_ready_i      = 1'b1;
    start_i         = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (meas_en_o) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_wait: meas_en never rose in 100 cycles");
    end
    f = freq_o;
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    start_i = 1'b0;
    check_idle_outputs("abort", f, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_outputs("abort_idle", f, 4'b0100);
    end
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    check_idle_outputs("start_abort", f, 4'b0100);
    @(negedge clk);
    check_idle_outputs("start_abort2", f, 4'b0100);
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    start_freq_i    = 32'd123456;
    stop_freq_i     = 32'd100;
    step_freq_i     = 32'd1000;
    settle_cycles_i = 16'd1;
    dwell_cycles_i  = 24'd2;
    wave_sel_i      = 4'b0010;
    pt_ready_i      = 1'b0;
    start_i         = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (pt_valid_o) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_wait: pt_valid never rose in 100 cycles");
    end
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check_idle_outputs("reset_mid", 32'd0, 4'b0001);
    @(negedge clk);
    check_idle_outputs("reset_mid2", 32'd0, 4'b0001);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
